// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: register map and CTRL bit layout.
package countdown_timer_pkg;

  localparam logic [1:0] TMR_LOAD   = 2'd0;
  localparam logic [1:0] TMR_CTRL   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PER     = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;

  typedef struct packed {
    logic ie;
    logic per;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/countdown_timer_if.sv
// MMIO write/read port of the countdown timer, plus its level interrupt.
interface countdown_timer_if #(parameter int WIDTH = 32) ();
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             irq;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data, irq);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data, irq);
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Tick divider for the countdown timer: counts 0..div while enabled and pulses
// tick on the terminal count. Only instantiated under TIMER_PRESCALE_EN.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // >= rather than == so a divisor lowered mid-count does not wrap the whole range
  assign tick = en && (cnt >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + PRE_W'(1);
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counting MMIO timer (one-shot / periodic) with sticky expiry
// flag and level irq. Optional prescaler compiled in with TIMER_PRESCALE_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  countdown_timer_if.slave bus
);

  logic [WIDTH-1:0] load, count, rd;
  ctrl_t            ctrl;
  logic             expired;
  logic             wr_load, wr_ctrl, wr_stat;
  logic             run, tick, expire;

  assign wr_load = bus.wr_en && (bus.wr_addr == TMR_LOAD);
  assign wr_ctrl = bus.wr_en && (bus.wr_addr == TMR_CTRL);
  assign wr_stat = bus.wr_en && (bus.wr_addr == TMR_STATUS);

  // A CTRL write that clears enable also kills this cycle's tick.
  assign run = ctrl.en && !(wr_ctrl && !bus.wr_data[CTRL_EN]);

`ifdef TIMER_PRESCALE_EN
  logic [PRE_W-1:0] prescale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prescale <= '0;
    else if (wr_ctrl) prescale <= bus.wr_data[CTRL_PRE_LSB +: PRE_W];
  end

  timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .clr  (wr_load),
    .div  (prescale),
    .tick (tick)
  );
`else
  assign tick = run;
`endif

  assign expire = tick && !wr_load && (count == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load  <= '0;
      count <= '0;
    end else if (wr_load) begin
      load  <= bus.wr_data;
      count <= bus.wr_data;
    end else if (tick) begin
      if (count > WIDTH'(1))  count <= count - WIDTH'(1);
      else if (expire)        count <= ctrl.per ? load : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.en  <= bus.wr_data[CTRL_EN];
      ctrl.per <= bus.wr_data[CTRL_PER];
      ctrl.ie  <= bus.wr_data[CTRL_IE];
    end else if (expire && !ctrl.per) begin
      ctrl.en <= 1'b0;
    end
  end

  // Set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           expired <= 1'b0;
    else if (expire)                      expired <= 1'b1;
    else if (wr_stat && bus.wr_data[0])   expired <= 1'b0;
  end

  always_comb begin
    rd = '0;
    unique case (bus.rd_addr)
      TMR_LOAD:  rd = load;
      TMR_CTRL: begin
        rd[CTRL_EN]  = ctrl.en;
        rd[CTRL_PER] = ctrl.per;
        rd[CTRL_IE]  = ctrl.ie;
`ifdef TIMER_PRESCALE_EN
        rd[CTRL_PRE_LSB +: PRE_W] = prescale;
`else
        rd[CTRL_PRE_LSB +: PRE_W] = {PRE_W{1'b0}};
`endif
      end
      TMR_COUNT:  rd = count;
      TMR_STATUS: rd[0] = expired;
      default:    rd = '0;
    endcase
  end

  assign bus.rd_data = rd;
  assign bus.irq     = expired && ctrl.ie;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer (default build or TIMER_PRESCALE_EN).
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  countdown_timer_if #(.WIDTH(32)) bus ();

  countdown_timer #(.WIDTH(32), .PRE_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                     input logic [1:0] ra, input logic [31:0] rd, input logic irq);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.exp_rd = rd; v.exp_irq = irq;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cycle(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                       input logic [1:0] ra);
    @(negedge clk);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] ra);
    cycle(1'b0, TMR_LOAD, 32'h0, ra);
  endtask

  initial begin
    logic [31:0] ctrl_hi;
    int n;
`ifdef TIMER_PRESCALE_EN
    ctrl_hi = 32'h0000_FF00;
`else
    ctrl_hi = 32'h0000_0000;
`endif

    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    #25;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1 check($sformatf("reset_rd%0d", a), bus.rd_data, 32'h0);
    end
    check("reset_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // one-shot, LOAD=3
    add(1, TMR_LOAD,   3,  TMR_LOAD,   3, 0);
    add(1, TMR_CTRL,   5,  TMR_COUNT,  3, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  2, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  1, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  0, 1);
    add(0, TMR_LOAD,   0,  TMR_STATUS, 1, 1);
    add(0, TMR_LOAD,   0,  TMR_CTRL,   4, 1);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  0, 1);
    add(1, TMR_STATUS, 1,  TMR_STATUS, 0, 0);
    // periodic, LOAD=4
    add(1, TMR_LOAD,   4,  TMR_COUNT,  4, 0);
    add(1, TMR_CTRL,   7,  TMR_COUNT,  4, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  3, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  2, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  1, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  4, 1);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  3, 1);
    add(1, TMR_STATUS, 1,  TMR_COUNT,  2, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  1, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  4, 1);
    // status clear colliding with expiry
    add(1, TMR_STATUS, 1,  TMR_COUNT,  3, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  2, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  1, 0);
    add(1, TMR_STATUS, 1,  TMR_COUNT,  4, 1);
    add(0, TMR_LOAD,   0,  TMR_STATUS, 1, 1);
    // LOAD write colliding with a tick
    add(1, TMR_LOAD,  10,  TMR_COUNT, 10, 1);
    add(0, TMR_LOAD,   0,  TMR_LOAD,  10, 1);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  8, 1);
    add(1, TMR_STATUS, 1,  TMR_COUNT,  7, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  6, 0);
    // freeze at 6, disable write discards the tick
    add(1, TMR_CTRL,   6,  TMR_COUNT,  6, 0);
    for (int i = 0; i < 5; i++) add(0, TMR_LOAD, 0, TMR_COUNT, 6, 0);
    add(1, TMR_CTRL,   7,  TMR_COUNT,  6, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  5, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  4, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  3, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  2, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT,  1, 0);
    add(0, TMR_LOAD,   0,  TMR_COUNT, 10, 1);
    // irq_en cleared drops irq but keeps the sticky flag
    add(1, TMR_CTRL,   3,  TMR_STATUS, 1, 0);
    add(0, TMR_LOAD,   0,  TMR_CTRL,   3, 0);
    add(1, TMR_CTRL,   32'hFFFF_FFF8, TMR_CTRL, ctrl_hi, 0);
    add(1, TMR_CTRL,   0,  TMR_CTRL,   0, 0);
    add(1, TMR_COUNT, 123, TMR_COUNT,  8, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra);
      check($sformatf("vec%0d_rd", i), bus.rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), 32'(bus.irq), 32'(vecs[i].exp_irq));
    end

    // asynchronous reset mid-count at COUNT=5
    cycle(1, TMR_LOAD, 8, TMR_COUNT);
    cycle(1, TMR_CTRL, 7, TMR_COUNT);
    idle(TMR_COUNT);
    idle(TMR_COUNT);
    idle(TMR_COUNT);
    check("pre_reset_count", bus.rd_data, 32'd5);
    check("pre_reset_irq", 32'(bus.irq), 32'h1);
    #1 rst_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1 check($sformatf("async_reset_rd%0d", a), bus.rd_data, 32'h0);
    end
    check("async_reset_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TIMER_PRESCALE_EN
    // LOAD=2, prescale=3, one-shot: expiry 8 cycles after enable
    cycle(1, TMR_LOAD, 2, TMR_COUNT);
    cycle(1, TMR_CTRL, 32'h0000_0305, TMR_CTRL);
    check("pre_ctrl_rd", bus.rd_data, 32'h0000_0305);
    n = 0;
    while (!bus.irq && n < 20) begin
      idle(TMR_COUNT);
      n++;
    end
    check("pre_expiry_cycles", 32'(n), 32'd8);
    check("pre_expiry_count", bus.rd_data, 32'd0);
`else
    n = 0;
    cycle(1, TMR_CTRL, 32'h0000_FF05, TMR_CTRL);
    check("noprescale_ctrl_rd", bus.rd_data, 32'h0000_0005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Memory-mapped programmable down-counting timer for the SoC I/O block. It complements the free-running up-counter: software loads a period, and the block counts down to expiry, raising a sticky status flag and an interrupt. Supports one-shot and periodic modes. Sits on the core's MMIO write/read path next to the cycle and instruction counters.

## Interface
- WIDTH, 32: counter and LOAD register width; also the data bus width.
- PRE_W, 8: prescaler divisor width; used only when the prescaler is compiled in.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  2  write register select.
- wr_data  in  WIDTH  write data.
- rd_addr  in  2  read register select.
- rd_data  out  WIDTH  read data, combinational from rd_addr and the current register state.
- irq  out  1  interrupt, level, equal to STATUS.expired AND CTRL.irq_en.

## Operation
- Register map:
  - 0 LOAD: read/write.
  - 1 CTRL: read/write. bit0 enable, bit1 periodic, bit2 irq_en; bits[8+PRE_W-1:8] prescale when the macro is defined. Unused bits read 0.
  - 2 COUNT: read-only; writes are ignored.
  - 3 STATUS: bit0 expired; writing 1 to bit0 clears it.
- Writing LOAD copies wr_data into LOAD and into COUNT on the same edge, and clears the prescaler.
- A tick is an enabled cycle in which the prescaler terminal count is reached. Without the prescaler, every enabled cycle is a tick.
- On a tick, the next state depends on COUNT:
  - COUNT>1: COUNT decrements by 1.
  - COUNT==1, periodic: COUNT reloads from LOAD and expired is set.
  - COUNT==1, one-shot: COUNT becomes 0, expired is set and enable clears.
  - COUNT==0: no change and no expiry. LOAD=0 means the timer is idle.
- Resulting period is LOAD ticks.
- Clearing enable freezes COUNT and the prescaler. Setting enable resumes from the frozen values.
- Arithmetic is unsigned WIDTH bits, so wrap below 0 cannot occur.
- Reset values: LOAD=0, CTRL=0, COUNT=0, STATUS=0, prescaler=0, irq=0, rd_data=0 for every address.

## Timing
- Write to visibility: a register write is visible on rd_data on the cycle after the wr_en edge.
- Expiry latency: expired and irq assert on the edge of the final tick.
- Example, prescale=0: enable set with LOAD=3 → irq high 3 cycles after the enable write takes effect.
- irq deasserts on the edge that writes STATUS=1 or writes CTRL.irq_en=0.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins and no decrement occurs.
  - STATUS clear and expiry in the same cycle: set wins and expired stays 1.
  - CTRL write clearing enable and a tick in the same cycle: the tick is discarded.
  - CTRL write and the one-shot auto-clear in the same cycle: the CTRL write value wins.
- Reset asserted mid-count returns all state to the reset values immediately, independent of clk.

## Configuration
- TIMER_PRESCALE_EN defined:
  - A PRE_W-bit prescaler counts 0..prescale.
  - One tick is issued when it reaches prescale, after which it returns to 0.
  - The period becomes LOAD×(prescale+1) cycles.
- TIMER_PRESCALE_EN undefined:
  - No prescaler logic is built.
  - CTRL bits[15:8] read 0.
  - Every enabled cycle is a tick.

## Structure
- Shared package holds:
  - register address constants: TMR_LOAD=0, TMR_CTRL=1, TMR_COUNT=2, TMR_STATUS=3;
  - CTRL bit indices: enable, periodic, irq_en, and the prescale field LSB=8.
- One sub-module, timer_prescaler:
  - inputs: clk, rst_n, en, clr, div[PRE_W-1:0];
  - output: tick;
  - instantiated only under TIMER_PRESCALE_EN.
- The register file and down-counter stay in countdown_timer.

## Test plan
- Reset: drive rst_n low mid-count with COUNT=5 → all four registers read 0 and irq=0 with no clock edge.
- One-shot:
  - Stimulus: LOAD=3, then CTRL=0b101.
  - Required: COUNT reads 2,1,0 on successive cycles; expired=1; irq=1; CTRL.enable reads 0; COUNT stays 0.
- Periodic:
  - Stimulus: LOAD=4, CTRL=0b111.
  - Required: expired sets every 4 cycles; COUNT sequence is 3,2,1,4,3,…
  - Required: write STATUS=1 → irq drops the next cycle, then reasserts at the next expiry.
- Collision:
  - STATUS clear in the same cycle as expiry → expired remains 1.
  - LOAD=10 written in the same cycle as a tick → COUNT reads 10.
- Freeze: clear enable at COUNT=6, hold 5 cycles → COUNT stays 6; re-enable → the next tick gives 5.
- Prescaler (TIMER_PRESCALE_EN):
  - Stimulus: LOAD=2, prescale=3, one-shot.
  - Required: expiry exactly 8 cycles after enable.
  - Build without the macro: CTRL bits[15:8] read 0.
